// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: hsync/vsync/de with per-sync polarity,
// frame-boundary shadowed timing, and a pass-through / test-pattern pixel mux.
module video_timing_gen #(
    parameter int HW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync_en,
    input  logic          hpol_i,
    input  logic          vpol_i,
    input  logic [1:0]    mode_i,
    input  logic [HW-1:0] hsw_i,
    input  logic [HW-1:0] hbp_i,
    input  logic [HW-1:0] hactive_i,
    input  logic [HW-1:0] hfp_i,
    input  logic [HW-1:0] vsw_i,
    input  logic [HW-1:0] vbp_i,
    input  logic [HW-1:0] vactive_i,
    input  logic [HW-1:0] vfp_i,
    input  logic [DW-1:0] solid_r_i,
    input  logic [DW-1:0] solid_g_i,
    input  logic [DW-1:0] solid_b_i,
    input  logic [DW-1:0] datar_i,
    input  logic [DW-1:0] datag_i,
    input  logic [DW-1:0] datab_i,
    output logic          req_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [DW-1:0] datar_o,
    output logic [DW-1:0] datag_o,
    output logic [DW-1:0] datab_o,
    output logic          sof_o,
    output logic [HW-1:0] x_o,
    output logic [HW-1:0] y_o,
    output logic [15:0]   frame_cnt_o
);

    // Totals and boundaries carry two extra bits so sums of four fields never wrap.
    localparam int TW = HW + 2;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic [HW-1:0] hsw;
        logic [HW-1:0] hbp;
        logic [HW-1:0] hact;
        logic [HW-1:0] hfp;
        logic [HW-1:0] vsw;
        logic [HW-1:0] vbp;
        logic [HW-1:0] vact;
        logic [HW-1:0] vfp;
        logic          hpol;
        logic          vpol;
        mode_e         mode;
    } cfg_t;

    function automatic logic [TW-1:0] ext(input logic [HW-1:0] a);
        return {2'b00, a};
    endfunction

    cfg_t          cfg_in;
    cfg_t          cfg_q;
    state_e        state;
    logic [TW-1:0] h_cnt;
    logic [TW-1:0] v_cnt;

    always_comb begin
        cfg_in.hsw  = hsw_i;
        cfg_in.hbp  = hbp_i;
        cfg_in.hact = hactive_i;
        cfg_in.hfp  = hfp_i;
        cfg_in.vsw  = vsw_i;
        cfg_in.vbp  = vbp_i;
        cfg_in.vact = vactive_i;
        cfg_in.vfp  = vfp_i;
        cfg_in.hpol = hpol_i;
        cfg_in.vpol = vpol_i;
        cfg_in.mode = mode_e'(mode_i);
    end

    logic [TW-1:0] in_htotal;
    logic [TW-1:0] in_vtotal;
    logic          legal_in;

    assign in_htotal = ext(hsw_i) + ext(hbp_i) + ext(hactive_i) + ext(hfp_i);
    assign in_vtotal = ext(vsw_i) + ext(vbp_i) + ext(vactive_i) + ext(vfp_i);
    assign legal_in  = (in_htotal >= TW'(2)) && (in_vtotal >= TW'(1));

    logic [TW-1:0] h_act_start;
    logic [TW-1:0] h_act_end;
    logic [TW-1:0] h_total;
    logic [TW-1:0] v_act_start;
    logic [TW-1:0] v_act_end;
    logic [TW-1:0] v_total;

    assign h_act_start = ext(cfg_q.hsw) + ext(cfg_q.hbp);
    assign h_act_end   = h_act_start + ext(cfg_q.hact);
    assign h_total     = h_act_end + ext(cfg_q.hfp);
    assign v_act_start = ext(cfg_q.vsw) + ext(cfg_q.vbp);
    assign v_act_end   = v_act_start + ext(cfg_q.vact);
    assign v_total     = v_act_end + ext(cfg_q.vfp);

    logic running;
    logic advance;
    logic h_last;
    logic v_last;
    logic hs;
    logic vs;
    logic act;
    logic frame_start;
    logic line_act_last;

    assign running       = (state == ST_RUN);
    assign advance       = running && sync_en;
    assign h_last        = (h_cnt == h_total - TW'(1));
    assign v_last        = (v_cnt == v_total - TW'(1));
    assign hs            = (h_cnt < ext(cfg_q.hsw));
    assign vs            = (v_cnt < ext(cfg_q.vsw));
    assign act           = running
                           && (h_cnt >= h_act_start) && (h_cnt < h_act_end)
                           && (v_cnt >= v_act_start) && (v_cnt < v_act_end);
    assign frame_start   = (h_cnt == '0) && (v_cnt == '0);
    assign line_act_last = (h_cnt == h_act_end - TW'(1));
    assign req_o         = act;

    logic [HW-1:0] x_cur;
    logic [HW-1:0] y_cur;

    assign x_cur = HW'(h_cnt - h_act_start);
    assign y_cur = HW'(v_cnt - v_act_start);

    // Idle until sync_en is seen, run while legal, park in HALT on an illegal capture
    // until sync_en drops and rises again.
    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cfg_q <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!sync_en) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cfg_q <= cfg_in;
                    state <= legal_in ? ST_RUN : ST_HALT;
                end
                ST_RUN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt <= '0;
                            cfg_q <= cfg_in;
                            state <= legal_in ? ST_RUN : ST_HALT;
                        end else begin
                            v_cnt <= v_cnt + TW'(1);
                        end
                    end else begin
                        h_cnt <= h_cnt + TW'(1);
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Colour-bar index tracks x / bar_width incrementally, saturating at the last bar.
    logic [HW-1:0] hact_div8;
    logic [HW-1:0] bar_w;
    logic [HW-1:0] bar_pix;
    logic [2:0]    bar_idx;
    logic [2:0]    bar_inv;

    assign hact_div8 = cfg_q.hact >> 3;
    assign bar_w     = (hact_div8 == '0) ? HW'(1) : hact_div8;
    assign bar_inv   = 3'd7 - bar_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (advance && act && !line_act_last) begin
            if (bar_pix == bar_w - HW'(1)) begin
                bar_pix <= '0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_pix <= bar_pix + HW'(1);
            end
        end else begin
            bar_pix <= '0;
            bar_idx <= '0;
        end
    end

    logic [DW-1:0] pix_r;
    logic [DW-1:0] pix_g;
    logic [DW-1:0] pix_b;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (act) begin
            unique case (cfg_q.mode)
                MODE_PASS: begin
                    pix_r = datar_i;
                    pix_g = datag_i;
                    pix_b = datab_i;
                end
                MODE_SOLID: begin
                    pix_r = solid_r_i;
                    pix_g = solid_g_i;
                    pix_b = solid_b_i;
                end
                MODE_BARS: begin
                    pix_r = {DW{bar_inv[2]}};
                    pix_g = {DW{bar_inv[1]}};
                    pix_b = {DW{bar_inv[0]}};
                end
                MODE_RAMP: begin
                    pix_r = DW'(x_cur);
                    pix_g = DW'(x_cur);
                    pix_b = DW'(x_cur);
                end
            endcase
        end
    end

    // Idle drives syncs to their inactive level from the live polarity inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_o     <= 1'b0;
            vsync_o     <= 1'b0;
            de_o        <= 1'b0;
            sof_o       <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            datar_o     <= '0;
            datag_o     <= '0;
            datab_o     <= '0;
            frame_cnt_o <= '0;
        end else if (advance) begin
            hsync_o <= ~(hs ^ cfg_q.hpol);
            vsync_o <= ~(vs ^ cfg_q.vpol);
            de_o    <= act;
            sof_o   <= frame_start;
            x_o     <= act ? x_cur : '0;
            y_o     <= act ? y_cur : '0;
            datar_o <= pix_r;
            datag_o <= pix_g;
            datab_o <= pix_b;
            if (frame_start) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end else begin
            hsync_o <= ~hpol_i;
            vsync_o <= ~vpol_i;
            de_o    <= 1'b0;
            sof_o   <= 1'b0;
            x_o     <= '0;
            y_o     <= '0;
            datar_o <= '0;
            datag_o <= '0;
            datab_o <= '0;
        end
    end

endmodule
